t03_nes_reader: RTL and testbench
=================================

// Module: t03_nes_reader
// PURPOSE
//  Host-side reader for an NES-style serial gamepad (4021 shift register).
//  Drives nes_latch/nes_clk, samples nes_data, and presents a parallel,
//  active-high 8-button vector to game logic.
//  It is the producer side of the button bus that game logic consumes
//  (the same bus normally stimulated directly on pb in simulation).
//  Sits between the board pads and the game FSM.
// PARAMETERS
//  HALF_CYC     60      clk cycles per half bit-period; >=3; latch high = 2*HALF_CYC
//  POLL_CYC     166667  idle clk cycles between frames (60 Hz at 10 MHz)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  en         in   1  polling enable; a frame in progress always completes
//  nes_data   in   1  serial data from pad, active-low, asynchronous
//  nes_latch  out  1  parallel-load strobe to pad, active-high
//  nes_clk    out  1  shift clock to pad; idles high
//  buttons    out  8  [7:0]={Right,Left,Down,Up,Start,Select,B,A}; 1 = pressed
//  valid      out  1  one-cycle pulse when buttons updated
//  pressed    out  8  one-cycle rising-edge mask (only with NES_PRESS_EDGE_EN)
// BEHAVIOUR
//  Reset (async): state=IDLE, counters=0, nes_latch=0, nes_clk=1,
//   buttons=0, valid=0, pressed=0, shift reg=0, sync flops=1 (released).
//  nes_data passes a 2-flop synchronizer; all sampling uses the synced value.
//  FSM: IDLE -> LATCH -> BIT_LO -> BIT_HI -> (BIT_LO | DONE) -> IDLE.
//   IDLE: count POLL_CYC cycles; at terminal count go LATCH if en=1,
//    else hold count at terminal and wait for en (start next cycle after en=1).
//   LATCH: nes_latch=1 for 2*HALF_CYC cycles; on last cycle sample bit0 (A).
//   BIT_LO: nes_clk=0 for HALF_CYC cycles.
//   BIT_HI: nes_clk=1 for HALF_CYC cycles; pad shifts on rising edge;
//    sample on last cycle into bit index 1..7; after bit7 go DONE.
//   DONE: 1 cycle; buttons <= ~shift (active-low inverted); valid=1.
//  Frame length: LATCH..BIT_HI = 16*HALF_CYC cycles, plus 1 DONE cycle;
//   valid asserts exactly 16*HALF_CYC+1 cycles after LATCH is entered.
//  buttons holds between frames; never changes outside DONE.
//  en deasserted mid-frame: no effect until return to IDLE.
//  Reset mid-frame: outputs return to reset values immediately; buttons
//   cleared, no valid pulse; polling restarts from IDLE count 0.
//  Pad disconnected (data floats high): reads as all released, buttons=0.
//  Counters sized $clog2(max(2*HALF_CYC,POLL_CYC)+1); no wrap in any state.
// CONFIGURATION
//  NES_PRESS_EDGE_EN defined: pressed = new_buttons & ~buttons_prev,
//   asserted same cycle as valid, 0 otherwise; lets game FSM act once per press.
//  Not defined: pressed tied to 8'h00; no extra flops.
// STRUCTURE
//  Package t03_nes_pkg: state enum (IDLE,LATCH,BIT_LO,BIT_HI,DONE),
//   button index localparams BTN_A=0..BTN_RIGHT=7, NUM_BTN=8.
//  Sub-module t03_nes_sync: 2-flop synchronizer, reset value 1.
//  Rest (FSM, timers, shift reg, output regs) in t03_nes_reader.
// TESTING  (HALF_CYC=3, POLL_CYC=10 unless noted)
//  1 Reset held, nes_data=0 -> nes_latch=0, nes_clk=1, buttons=0, valid=0.
//  2 Pad model presents A+Start (serial 0,1,1,0,1,1,1,1) -> buttons=8'h09,
//    valid one pulse, 49 cycles after LATCH entered.
//  3 Pad model all-high -> buttons=8'h00 each frame; latch width exactly
//    6 cycles; 7 nes_clk low pulses of 3 cycles per frame.
//  4 en=0 from reset -> no latch for 200 cycles; raise en -> LATCH the cycle after.
//  5 Assert rst at BIT_HI of bit4 -> nes_clk=1, buttons=0 same cycle,
//    no valid; after release first LATCH after 10 idle cycles.
//  6 NES_PRESS_EDGE_EN: frame1 Up, frame2 Up+B -> pressed=8'h10 then 8'h02;
//    frame3 same -> pressed=8'h00. Without macro pressed always 8'h00.

Source files
------------

// File: rtl/t03_nes_pkg.sv
// rtl/t03_nes_pkg.sv - shared types and constants for the NES gamepad reader
//
// Contents:
//   state_t          reader FSM states (IDLE, LATCH, BIT_LO, BIT_HI, DONE)
//   BTN_A..BTN_RIGHT bit positions of each button in the parallel vector
//   NUM_BTN          number of buttons shifted out of the pad per frame
package t03_nes_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        BIT_LO = 3'd2,
        BIT_HI = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int NUM_BTN   = 8;

    // Serial order out of the 4021: A first, Right last.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/t03_nes_sync.sv
// rtl/t03_nes_sync.sv - two-flop synchronizer for the pad data line
//
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset; both flops preset to 1
//   d    in  asynchronous input
//   q    out synchronized output
//
// Presetting to 1 makes the line read as "released" (the pad is active-low)
// until real data has propagated through.
module t03_nes_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/t03_nes_reader.sv
// rtl/t03_nes_reader.sv - host-side NES gamepad (4021) serial reader
//
// Drives nes_latch/nes_clk, samples nes_data and presents an active-high
// 8-button vector with a one-cycle valid pulse per poll frame.
//
// Parameters:
//   HALF_CYC  clk cycles per half bit-period (>=3); latch is 2*HALF_CYC wide
//   POLL_CYC  idle clk cycles between frames
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   en         in   polling enable; a frame in progress always completes
//   nes_data   in   serial data from pad, active-low, asynchronous
//   nes_latch  out  parallel-load strobe to pad, active-high
//   nes_clk    out  shift clock to pad, idles high
//   buttons    out  {Right,Left,Down,Up,Start,Select,B,A}, 1 = pressed
//   valid      out  one-cycle pulse when buttons is updated
//   pressed    out  newly pressed buttons, same cycle as valid
//
// Build option NES_PRESS_EDGE_EN: when defined, pressed reports the rising
// edges of buttons; otherwise pressed is constant zero and costs no flops.
module t03_nes_reader
    import t03_nes_pkg::*;
#(
    parameter int HALF_CYC = 60,
    parameter int POLL_CYC = 166667
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               nes_data,
    output logic               nes_latch,
    output logic               nes_clk,
    output logic [NUM_BTN-1:0] buttons,
    output logic               valid,
    output logic [NUM_BTN-1:0] pressed
);

    localparam int CNT_MAX = (2 * HALF_CYC > POLL_CYC) ? 2 * HALF_CYC : POLL_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] POLL_TC  = CW'(POLL_CYC - 1);
    localparam logic [CW-1:0] LATCH_TC = CW'(2 * HALF_CYC - 1);
    localparam logic [CW-1:0] HALF_TC  = CW'(HALF_CYC - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2:0]         bit_idx;
    logic [NUM_BTN-1:0] shift;
    logic               data_s;

    t03_nes_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (nes_data),
        .q   (data_s)
    );

`ifdef NES_PRESS_EDGE_EN
    logic [NUM_BTN-1:0] pressed_q;
    assign pressed = pressed_q;
`else
    assign pressed = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            nes_latch <= 1'b0;
            nes_clk   <= 1'b1;
            buttons   <= '0;
            valid     <= 1'b0;
`ifdef NES_PRESS_EDGE_EN
            pressed_q <= '0;
`endif
        end else begin
            valid <= 1'b0;
`ifdef NES_PRESS_EDGE_EN
            pressed_q <= '0;
`endif
            case (state)
                IDLE: begin
                    // Count saturates at terminal while polling is disabled,
                    // so the frame starts the cycle after en returns.
                    if (cnt == POLL_TC) begin
                        if (en) begin
                            state     <= LATCH;
                            cnt       <= '0;
                            nes_latch <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                LATCH: begin
                    if (cnt == LATCH_TC) begin
                        // A is already on the data line while latch is high.
                        shift[BTN_A] <= data_s;
                        state        <= BIT_LO;
                        cnt          <= '0;
                        bit_idx      <= 3'd1;
                        nes_latch    <= 1'b0;
                        nes_clk      <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BIT_LO: begin
                    if (cnt == HALF_TC) begin
                        state   <= BIT_HI;
                        cnt     <= '0;
                        nes_clk <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BIT_HI: begin
                    // Pad shifted on the rising edge; sampling at the end of
                    // the high phase leaves time for the synchronizer.
                    if (cnt == HALF_TC) begin
                        shift[bit_idx] <= data_s;
                        cnt            <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= DONE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            state   <= BIT_LO;
                            nes_clk <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    buttons <= ~shift;
                    valid   <= 1'b1;
`ifdef NES_PRESS_EDGE_EN
                    pressed_q <= ~shift & ~buttons;
`endif
                    state <= IDLE;
                    cnt   <= '0;
                end

                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    nes_latch <= 1'b0;
                    nes_clk   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t03_nes_reader.sv
// tb/tb_t03_nes_reader.sv - self-checking bench for t03_nes_reader
module tb_t03_nes_reader;
    import t03_nes_pkg::*;

    localparam int H      = 3;
    localparam int P      = 10;
    localparam int FRAME  = 16 * H + 1;
    localparam int PERIOD = P + FRAME;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_clk;
    logic [7:0] buttons;
    logic       valid;
    logic [7:0] pressed;

    logic [7:0] pad_btn  = 8'h00;
    logic       pad_conn = 1'b1;
    logic       ovr_en   = 1'b0;
    logic       ovr_val  = 1'b0;
    logic [7:0] sr       = 8'hFF;
    logic       chk_on   = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    t03_nes_reader #(.HALF_CYC(H), .POLL_CYC(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .nes_data  (nes_data),
        .nes_latch (nes_latch),
        .nes_clk   (nes_clk),
        .buttons   (buttons),
        .valid     (valid),
        .pressed   (pressed)
    );

    // 4021 pad: parallel load while latched, shift toward output on nes_clk rise.
    always @(posedge nes_clk or posedge nes_latch) begin
        if (nes_latch) sr <= ~pad_btn;
        else           sr <= {1'b1, sr[7:1]};
    end
    assign nes_data = ovr_en ? ovr_val : (pad_conn ? sr[0] : 1'b1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Timeline model: position p within one poll period.
    int         p;
    logic       mvalid;
    logic [7:0] mbtn, mframe, mpress;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p      <= 0;
            mvalid <= 1'b0;
            mbtn   <= 8'h00;
            mframe <= 8'h00;
            mpress <= 8'h00;
        end else begin
            mvalid <= 1'b0;
            mpress <= 8'h00;
            if (p == P - 1 && !en) begin
                p <= p;
            end else if (p == PERIOD - 1) begin
                p      <= 0;
                mvalid <= 1'b1;
                mbtn   <= mframe;
`ifdef NES_PRESS_EDGE_EN
                mpress <= mframe & ~mbtn;
`endif
            end else begin
                p <= p + 1;
            end
            if (p == P - 1 && en) mframe <= pad_conn ? pad_btn : 8'h00;
        end
    end

    function automatic logic exp_latch(input int pp);
        return (pp >= P) && (pp < P + 2 * H);
    endfunction

    function automatic logic exp_nclk(input int pp);
        int q;
        q = pp - (P + 2 * H);
        return !((q >= 0) && (q < 14 * H) && ((q % (2 * H)) < H));
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_latch",   nes_latch, exp_latch(p));
            check("cyc_nes_clk", nes_clk,   exp_nclk(p));
            check("cyc_valid",   valid,     mvalid);
            check("cyc_buttons", buttons,   mbtn);
            check("cyc_pressed", pressed,   mpress);
        end
    end

    task automatic wait_latch(output int k);
        k = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (nes_latch) begin k = i; break; end
        end
        if (k == 0) check("latch_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (valid) begin k = i; break; end
        end
        if (k == 0) check("valid_timeout", 0, 1);
    endtask

    function automatic logic [7:0] exp_press(input logic [7:0] v);
`ifdef NES_PRESS_EDGE_EN
        return v;
`else
        return (v & 8'h00);
`endif
    endfunction

    initial begin
        int k, lat, low, pulses;
        logic prev;

        // 1: reset held with data low
        ovr_en  = 1'b1;
        ovr_val = 1'b0;
        en      = 1'b1;
        pad_btn = (8'h1 << BTN_A) | (8'h1 << BTN_START);
        chk_on  = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_latch",   nes_latch, 1'b0);
        check("rst_nes_clk", nes_clk,   1'b1);
        check("rst_buttons", buttons,   8'h00);
        check("rst_valid",   valid,     1'b0);
        check("rst_pressed", pressed,   8'h00);
        rst    = 1'b0;
        ovr_en = 1'b0;

        // 2: A+Start
        wait_latch(k);
        check("first_latch_delay", k, 10);
        wait_valid(k);
        check("valid_latency", k, 49);
        check("buttons_a_start", buttons, 8'h09);

        // 3: all released, frame shape
        pad_btn = 8'h00;
        wait_latch(k);
        lat = 1; low = 0; pulses = 0; prev = nes_clk;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (valid) break;
            lat += int'(nes_latch);
            if (!nes_clk) low++;
            if (!nes_clk && prev) pulses++;
            prev = nes_clk;
        end
        check("latch_width", lat, 6);
        check("clk_low_cycles", low, 21);
        check("clk_low_pulses", pulses, 7);
        check("buttons_released", buttons, 8'h00);

        pad_btn = 8'hA5;
        wait_valid(k);
        check("buttons_a5", buttons, 8'hA5);
        pad_conn = 1'b0;
        wait_valid(k);
        check("buttons_disconnected", buttons, 8'h00);
        pad_conn = 1'b1;

        // en dropped mid-frame: frame completes, then polling stops
        wait_latch(k);
        repeat (5) @(posedge clk);
        #1 en = 1'b0;
        wait_valid(k);
        check("midframe_en_valid", k > 0, 1'b1);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat += int'(nes_latch);
        end
        check("no_latch_after_en_drop", lat, 0);

        // 4: en low from reset
        @(negedge clk) rst = 1'b1;
        pad_btn = 8'h3C;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat += int'(nes_latch);
        end
        check("en_low_no_latch", lat, 0);
        en = 1'b1;
        @(posedge clk); #1;
        check("latch_after_en", nes_latch, 1'b1);
        wait_valid(k);
        check("buttons_3c", buttons, 8'h3C);

        // 5: reset during BIT_HI of bit 4
        pad_btn = 8'h1 << BTN_UP;
        wait_latch(k);
        repeat (27) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_nes_clk", nes_clk,   1'b1);
        check("midrst_buttons", buttons,   8'h00);
        check("midrst_latch",   nes_latch, 1'b0);
        check("midrst_valid",   valid,     1'b0);
        @(negedge clk) rst = 1'b0;
        wait_latch(k);
        check("latch_after_midrst", k, 10);

        // 6: press edges
        wait_valid(k);
        check("buttons_up", buttons, 8'h10);
        check("pressed_up", pressed, exp_press(8'h10));
        pad_btn = (8'h1 << BTN_UP) | (8'h1 << BTN_B);
        wait_valid(k);
        check("buttons_up_b", buttons, 8'h12);
        check("pressed_b", pressed, exp_press(8'h02));
        wait_valid(k);
        check("buttons_hold", buttons, 8'h12);
        check("pressed_none", pressed, 8'h00);

        @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
